spi_txq: RTL and testbench

- Transmit queue in front of the 8-bit SPI output driver on the 62.5 MHz domain.
- The CPU posts 10-bit display words into a FIFO with one store each (write-enable = chip-select && memwrite), instead of busy-waiting per byte.
- The block drains the FIFO into the driver one word at a time. It issues a start only when the driver is idle, judged from the driver's active-low chip-select output.
- A 32-bit status word is returned on the CPU read-data mux.

---
 rtl/spi_txq.sv | 127 ++++++++++++
 tb/tb_spi_txq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txq.sv
`timescale 1ns/1ps
// spi_txq: CPU-posted transmit FIFO that feeds the SPI output driver one word
// per start pulse, issuing a start only while the driver's chip-select is idle.
module spi_txq #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ACK_TMO = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [9:0]  wdata,
  input  logic        flush,
  input  logic        clr_ovf,
  input  logic        spi_cs_n,
  output logic        spi_start,
  output logic [9:0]  spi_din,
  output logic [31:0] status,
  output logic        empty,
  output logic        full
);
  localparam int            TW       = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, ACK, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_empty, r_full, r_ovf;
  logic          r_start, w_start_nxt;
  logic [9:0]    r_din, w_din_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [31:0]   r_status;
  logic          w_pop, w_push, w_drop;

  // A pop is only ever taken on the IDLE->ISSUE edge, so a full queue can
  // still accept a word on that same edge.
  assign w_pop  = (r_state == IDLE) && !r_empty && spi_cs_n;
  assign w_push = wr && !flush && (!r_full || w_pop);
  assign w_drop = wr && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (flush)                 w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_FULL);
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_start  <= 1'b0;
      r_din    <= '0;
      r_tmo    <= '0;
      r_status <= 32'h0000_0100;
    end else begin
      r_state  <= w_state_nxt;
      r_start  <= w_start_nxt;
      r_din    <= w_din_nxt;
      r_tmo    <= w_tmo_nxt;
      r_status <= {20'd0, r_ovf, (r_state != IDLE), r_full, r_empty, 8'(r_count)};
    end
  end

  // Power-on commands never see chip-select drop, so they skip the ack wait.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_din[9] ? HOLD : ACK;
      HOLD:    w_state_nxt = IDLE;
      ACK:     if (!spi_cs_n)            w_state_nxt = DONE;
               else if (r_tmo == TMO_LAST) w_state_nxt = IDLE;
      DONE:    if (spi_cs_n) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start_nxt = w_pop;
    w_din_nxt   = w_pop ? r_mem[r_rptr] : r_din;
    w_tmo_nxt   = r_tmo;
    if (r_state == ISSUE)    w_tmo_nxt = '0;
    else if (r_state == ACK) w_tmo_nxt = r_tmo + 1'b1;
  end

  assign spi_start = r_start;
  assign spi_din   = r_din;
  assign status    = r_status;
  assign empty     = r_empty;
  assign full      = r_full;
endmodule

// File: tb/tb_spi_txq.sv
`timescale 1ns/1ps
// Bench for spi_txq: scoreboard of pushed words against observed start pulses,
// with a behavioural SPI driver whose chip-select response is selectable.
module tb_spi_txq;
  localparam int DRV_NORM = 0, DRV_HI = 1, DRV_LOW = 2;

  logic        clk = 1'b0, reset_n = 1'b1, wr = 1'b0, flush = 1'b0, clr_ovf = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [9:0]  wdata = '0;
  logic        spi_start, empty, full;
  logic [9:0]  spi_din;
  logic [31:0] status;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int drv_mode = DRV_NORM, drv_len = 4, drv_cnt = 0;

  typedef struct { logic [9:0] d; int c; } obs_t;
  obs_t       obs[$];
  logic [9:0] exp_q[$];

  spi_txq #(.DEPTH(16), .AW(4), .ACK_TMO(3)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .wdata(wdata), .flush(flush),
    .clr_ovf(clr_ovf), .spi_cs_n(spi_cs_n), .spi_start(spi_start),
    .spi_din(spi_din), .status(status), .empty(empty), .full(full));

  always #8 clk = ~clk;

  // Start monitor plus driver model: chip-select drops the cycle after a
  // start and stays low drv_len cycles; power commands are ignored.
  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (spi_start === 1'b1) begin o.d = spi_din; o.c = cyc; obs.push_back(o); end
      if (!reset_n) begin spi_cs_n = 1'b1; drv_cnt = 0; end
      else if (drv_mode == DRV_HI)  spi_cs_n = 1'b1;
      else if (drv_mode == DRV_LOW) spi_cs_n = 1'b0;
      else if (drv_cnt != 0) begin drv_cnt--; spi_cs_n = (drv_cnt == 0); end
      else if (spi_start && !spi_din[9]) begin spi_cs_n = 1'b0; drv_cnt = drv_len; end
      else spi_cs_n = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got sim time limit want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick; @(negedge clk); endtask

  task automatic push_word(input logic [9:0] d, input bit expect_it);
    wr = 1'b1; wdata = d;
    if (expect_it) exp_q.push_back(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && obs.size() < n; i++) tick();
    ok = (obs.size() >= n);
  endtask

  task automatic test_reset;
    tick();
    reset_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", spi_start); end
    n_chk++; if (spi_din !== 10'h0) begin n_fail++; $display("FAIL rst_din: got %h want 000", spi_din); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_status: got %h want 00000100", status); end
    reset_n = 1'b1;
    repeat (2) tick();
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_status_post: got %h want 00000100", status); end
  endtask

  task automatic test_single;
    int t0, bad, n; bit ok; obs_t o; logic [9:0] e;
    drv_mode = DRV_NORM; drv_len = 450; obs.delete(); exp_q.delete();
    t0 = cyc;
    push_word(10'h0A5, 1'b1);
    wait_obs(1, 10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_start: got no start want start within 10 cycles"); end
    else begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o.d !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", o.d, e); end
      n_chk++; if (o.c !== t0 + 2) begin n_fail++; $display("FAIL single_latency: got edge %0d want %0d", o.c, t0 + 2); end
    end
    tick();
    n_chk++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", spi_start); end
    bad = 0; n = 0;
    while (spi_cs_n === 1'b0 && n < 600) begin
      if (status[10] !== 1'b1) bad++;
      tick(); n++;
    end
    n_chk++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL single_cs_rise: got %b want 1", spi_cs_n); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL single_busy: got %0d idle samples want 0", bad); end
    repeat (3) tick();
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL single_status_end: got %h want 00000100", status); end
  endtask

  task automatic test_burst;
    logic [7:0] mx; bit ok;
    drv_mode = DRV_NORM; drv_len = 6; obs.delete(); exp_q.delete();
    push_word(10'h100, 1'b1); push_word(10'h1FF, 1'b1); push_word(10'h033, 1'b1);
    mx = '0;
    repeat (10) begin if (status[7:0] > mx) mx = status[7:0]; tick(); end
    n_chk++; if (mx !== 8'd2) begin n_fail++; $display("FAIL burst_peak: got %0d want 2", mx); end
    wait_obs(3, 60, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL burst_starts: got %0d starts want 3", obs.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (obs[i].d !== exp_q[i]) begin n_fail++; $display("FAIL burst_data%0d: got %h want %h", i, obs[i].d, exp_q[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_chk++; if (obs[i].c - obs[i-1].c !== drv_len + 2) begin n_fail++; $display("FAIL burst_gap%0d: got %0d want %0d", i, obs[i].c - obs[i-1].c, drv_len + 2); end
      end
    end
    repeat (12) tick();
  endtask

  task automatic test_power;
    bit ok; logic [2:0] pat;
    drv_mode = DRV_NORM; drv_len = 3; obs.delete(); exp_q.delete();
    push_word(10'h200, 1'b1); push_word(10'h155, 1'b1);
    wait_obs(1, 5, ok);
    pat = '0;
    for (int i = 2; i >= 0; i--) begin tick(); pat[i] = status[10]; end
    n_chk++; if (pat !== 3'b110) begin n_fail++; $display("FAIL power_busy: got %b want 110", pat); end
    wait_obs(2, 20, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL power_starts: got %0d starts want 2", obs.size()); end
    else begin
      n_chk++; if (obs[0].d !== exp_q[0]) begin n_fail++; $display("FAIL power_data0: got %h want %h", obs[0].d, exp_q[0]); end
      n_chk++; if (obs[1].d !== exp_q[1]) begin n_fail++; $display("FAIL power_data1: got %h want %h", obs[1].d, exp_q[1]); end
      n_chk++; if (obs[1].c - obs[0].c !== 3) begin n_fail++; $display("FAIL power_gap: got %0d want 3", obs[1].c - obs[0].c); end
    end
    repeat (10) tick();
  endtask

  task automatic test_overflow;
    drv_mode = DRV_LOW; obs.delete(); exp_q.delete();
    repeat (2) tick();
    for (int i = 0; i < 16; i++) push_word(10'(i * 37 + 5) & 10'h1FF, 1'b1);
    n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", empty); end
    push_word(10'h3FF, 1'b0);
    tick();
    n_chk++; if (status !== 32'h0000_0A10) begin n_fail++; $display("FAIL ovf_status: got %h want 00000a10", status); end
    clr_ovf = 1'b1;
    push_word(10'h3FE, 1'b0);
    clr_ovf = 1'b0;
    tick();
    n_chk++; if (status[11] !== 1'b1) begin n_fail++; $display("FAIL ovf_wins_clr: got %b want 1", status[11]); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; tick();
    n_chk++; if (status !== 32'h0000_0210) begin n_fail++; $display("FAIL ovf_cleared: got %h want 00000210", status); end
    n_chk++; if (obs.size() != 0) begin n_fail++; $display("FAIL ovf_no_start: got %0d starts want 0", obs.size()); end
  endtask

  // Continues from the full queue left by test_overflow.
  task automatic test_wrap;
    bit ok;
    drv_mode = DRV_NORM; drv_len = 4;
    tick();
    for (int k = 16; k < 40; k++) begin
      push_word(10'(k * 37 + 5) & 10'h1FF, 1'b1);
      n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full%0d: got %b want 1", k, full); end
      repeat (drv_len + 1) tick();
    end
    n_chk++; if (status[11] !== 1'b0) begin n_fail++; $display("FAIL wrap_no_ovf: got %b want 0", status[11]); end
    wait_obs(40, 400, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wrap_starts: got %0d starts want 40", obs.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        n_chk++; if (obs[i].d !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", i, obs[i].d, exp_q[i]); end
      end
    end
    repeat (8) tick();
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL wrap_status_end: got %h want 00000100", status); end
  endtask

  task automatic test_timeout;
    bit ok;
    drv_mode = DRV_HI; obs.delete(); exp_q.delete();
    tick();
    push_word(10'h011, 1'b1); push_word(10'h022, 1'b1);
    wait_obs(2, 30, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tmo_starts: got %0d starts want 2", obs.size()); end
    else begin
      n_chk++; if (obs[0].d !== exp_q[0]) begin n_fail++; $display("FAIL tmo_data0: got %h want %h", obs[0].d, exp_q[0]); end
      n_chk++; if (obs[1].d !== exp_q[1]) begin n_fail++; $display("FAIL tmo_data1: got %h want %h", obs[1].d, exp_q[1]); end
      n_chk++; if (obs[1].c - obs[0].c !== 5) begin n_fail++; $display("FAIL tmo_gap: got %0d want 5", obs[1].c - obs[0].c); end
    end
    repeat (10) tick();
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL tmo_idle: got %h want 00000100", status); end
  endtask

  task automatic test_flush;
    drv_mode = DRV_LOW; obs.delete(); exp_q.delete();
    repeat (2) tick();
    for (int i = 1; i <= 5; i++) push_word(10'(i), 1'b0);
    tick();
    n_chk++; if (status[7:0] !== 8'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", status[7:0]); end
    flush = 1'b1; wr = 1'b1; wdata = 10'h3AA;
    tick();
    flush = 1'b0; wr = 1'b0;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty); end
    tick();
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_status: got %h want 00000100", status); end
    drv_mode = DRV_NORM;
    repeat (10) tick();
    n_chk++; if (obs.size() != 0) begin n_fail++; $display("FAIL flush_no_start: got %0d starts want 0", obs.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    drv_mode = DRV_NORM; drv_len = 50; obs.delete(); exp_q.delete();
    push_word(10'h0C3, 1'b1); push_word(10'h111, 1'b0); push_word(10'h122, 1'b0);
    wait_obs(1, 10, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_start: got no start want 1"); end
    obs.delete();
    repeat (6) tick();
    n_chk++; if (status[10] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b want 1", status[10]); end
    n_chk++; if (spi_din !== 10'h0C3) begin n_fail++; $display("FAIL rmid_din: got %h want 0c3", spi_din); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start_rst: got %b want 0", spi_start); end
    n_chk++; if (spi_din !== 10'h0) begin n_fail++; $display("FAIL rmid_din_rst: got %h want 000", spi_din); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty_rst: got %b want 1", empty); end
    n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL rmid_full_rst: got %b want 0", full); end
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL rmid_status_rst: got %h want 00000100", status); end
    tick(); tick();
    reset_n = 1'b1;
    repeat (10) tick();
    n_chk++; if (obs.size() != 0) begin n_fail++; $display("FAIL rmid_no_restart: got %0d starts want 0", obs.size()); end
    n_chk++; if (status !== 32'h0000_0100) begin n_fail++; $display("FAIL rmid_status_end: got %h want 00000100", status); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_power();
    test_overflow();
    test_wrap();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
